// File: rtl/mux21_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux21_rr_arbiter_pkg
// Shared definitions for the 2:1 class merge arbiter. The lane ids are the same
// encoding the upstream 1:2 class demux uses for its classification bit, so a
// class_out value can be compared directly against the demux classif field.
// -----------------------------------------------------------------------------
package mux21_rr_arbiter_pkg;

  // Data word width of both lanes and of the merged stream.
  localparam int BW    = 10;
  // Width of the per-lane forwarded-word counters (wrap, no saturation).
  localparam int CNT_W = 8;

  // Lane / class identifiers.
  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

  // The lane that is not the given one; used to advance the round-robin pointer.
  function automatic lane_e other_lane(input lane_e lane);
    lane_e res;
    if (lane == LANE0) begin
      res = LANE1;
    end else begin
      res = LANE0;
    end
    return res;
  endfunction

endpackage

// File: rtl/mux21_rr_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// mux21_rr_arbiter_rr_arb2
// Two-input round-robin arbiter. Produces a combinational one-hot grant from the
// two eligibility requests and keeps the pointer that decides ties.
//
// Ports:
//   clk     in   clock, posedge
//   reset   in   synchronous, active-low; pointer returns to "lane 0 first"
//   elig_0  in   lane 0 may be granted this cycle
//   elig_1  in   lane 1 may be granted this cycle
//   grant   out  one-hot grant, bit i = lane i (combinational, registered by the
//                parent as the pop strobes)
// -----------------------------------------------------------------------------
module mux21_rr_arbiter_rr_arb2
  import mux21_rr_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       elig_0,
  input  logic       elig_1,
  output logic [1:0] grant
);

  lane_e ptr;
  lane_e ptr_next;

  // Grant selection and pointer update. The pointer always moves past the lane
  // that was just served, so after a stall the other lane is favoured and the
  // alternation resumes where it left off.
  always_comb begin
    grant    = 2'b00;
    ptr_next = ptr;
    case ({elig_1, elig_0})
      2'b01: begin
        grant = 2'b01;
      end
      2'b10: begin
        grant = 2'b10;
      end
      2'b11: begin
        if (ptr == LANE0) begin
          grant = 2'b01;
        end else begin
          grant = 2'b10;
        end
      end
      default: begin
        grant = 2'b00;
      end
    endcase

    if (grant[0]) begin
      ptr_next = other_lane(LANE0);
    end else if (grant[1]) begin
      ptr_next = other_lane(LANE1);
    end else begin
      ptr_next = ptr;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= LANE0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/mux21_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux21_rr_arbiter
// Merges the class-0 and class-1 lane FIFOs back into one word stream, tagging
// each word with the lane it came from. Pops are round-robin arbitrated and are
// held off while the downstream FIFO reports almost-full.
//
// Pipeline (edge numbering relative to the grant edge E):
//   E    : arbitration, pop_g registered high
//   E+1  : FIFO sees the pop; in-flight valid/sel registered
//   E+2  : FIFO read data captured into data_out, push_out high, counter bumps
//
// Ports:
//   clk          in   clock, posedge
//   reset        in   synchronous, active-low
//   empty_0/1    in   lane FIFO empty flags (lag the pop by one cycle)
//   data_0/1     in   lane FIFO read data, valid the cycle after the pop
//   almost_full  in   downstream almost-full; blocks new grants only
//   pop_0/1      out  lane read strobes (registered, never both high)
//   data_out     out  merged word
//   push_out     out  data_out valid / downstream write strobe
//   class_out    out  source lane of data_out
//   cnt_0/1      out  words forwarded per lane, wrapping
// -----------------------------------------------------------------------------
module mux21_rr_arbiter
  import mux21_rr_arbiter_pkg::*;
#(
  parameter int BW    = mux21_rr_arbiter_pkg::BW,
  parameter int CNT_W = mux21_rr_arbiter_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             empty_0,
  input  logic             empty_1,
  input  logic [BW-1:0]    data_0,
  input  logic [BW-1:0]    data_1,
  input  logic             almost_full,
  output logic             pop_0,
  output logic             pop_1,
  output logic [BW-1:0]    data_out,
  output logic             push_out,
  output logic             class_out,
  output logic [CNT_W-1:0] cnt_0,
  output logic [CNT_W-1:0] cnt_1
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic          elig_0;
  logic          elig_1;
  logic [1:0]    grant;
  logic          flight_v;
  lane_e         flight_sel;
  logic [BW-1:0] flight_data;

  // A lane popped last cycle is not eligible again: its empty flag has not yet
  // caught up with that pop, so a second pop could underrun the FIFO.
  assign elig_0 = !empty_0 && !pop_0 && !almost_full;
  assign elig_1 = !empty_1 && !pop_1 && !almost_full;

  mux21_rr_arbiter_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .elig_0 (elig_0),
    .elig_1 (elig_1),
    .grant  (grant)
  );

  // Select the read data of the lane whose pop is now being answered.
  always_comb begin
    flight_data = data_0;
    if (flight_sel == LANE1) begin
      flight_data = data_1;
    end else begin
      flight_data = data_0;
    end
  end

  // Pop strobes and the one-deep in-flight tracker (which lane answers next).
  always_ff @(posedge clk) begin
    if (!reset) begin
      pop_0      <= 1'b0;
      pop_1      <= 1'b0;
      flight_v   <= 1'b0;
      flight_sel <= LANE0;
    end else begin
      pop_0      <= grant[0];
      pop_1      <= grant[1];
      flight_v   <= pop_0 | pop_1;
      flight_sel <= pop_1 ? LANE1 : LANE0;
    end
  end

  // Output stage: forward the answered word; data/class hold when idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out  <= {BW{1'b0}};
      class_out <= 1'b0;
      push_out  <= 1'b0;
    end else if (flight_v) begin
      data_out  <= flight_data;
      class_out <= flight_sel;
      push_out  <= 1'b1;
    end else begin
      push_out  <= 1'b0;
    end
  end

  // Per-lane forwarded-word counters; wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_0 <= {CNT_W{1'b0}};
      cnt_1 <= {CNT_W{1'b0}};
    end else if (flight_v) begin
      if (flight_sel == LANE1) begin
        cnt_1 <= cnt_1 + CNT_ONE;
      end else begin
        cnt_0 <= cnt_0 + CNT_ONE;
      end
    end else begin
      cnt_0 <= cnt_0;
      cnt_1 <= cnt_1;
    end
  end

endmodule
